// File: rtl/frame_parity_unit.sv
// Streaming frame parity: folds the XOR of each accepted word into a running bit
// and returns one parity/error/count/overflow result per frame on a valid/ready port.
module frame_parity_unit #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 16,
  localparam int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
  input  logic             check_mode,
  input  logic             in_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_error,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow,
  output logic [0:0]       dbg_state
);

  localparam logic [0:0]    ST_ACCUM = 1'b0;
  localparam logic [0:0]    ST_DONE  = 1'b1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_WORDS);

  // Handshake: a transfer happens on a port in any cycle where valid and ready are
  // both high; ready depends on state only, and out_* hold while out_valid waits.
  logic [0:0]    r_state;
  logic          r_first;
  logic          r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_odd;
  logic          r_check;
  logic          r_out_parity;
  logic          r_out_error;
  logic [CW-1:0] r_out_count;
  logic          r_out_ovf;

  logic          w_beat;
  logic          w_word_par;
  logic          w_acc_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_ovf_next;
  logic          w_odd_eff;
  logic          w_check_eff;
  logic          w_parity_final;

  assign w_beat     = in_valid && (r_state == ST_ACCUM);
  assign w_word_par = ^in_data;

  // Mode bits come straight from the pins on the first beat so a one-beat frame sees them.
  always_comb begin
    w_acc_next  = r_acc ^ w_word_par;
    w_cnt_next  = r_cnt;
    w_ovf_next  = r_ovf;
    w_odd_eff   = r_odd;
    w_check_eff = r_check;
    if (r_first) begin
      w_acc_next  = w_word_par;
      w_cnt_next  = CW'(1);
      w_ovf_next  = 1'b0;
      w_odd_eff   = odd_mode;
      w_check_eff = check_mode;
    end else if (r_cnt == MAX_CNT) begin
      w_ovf_next = 1'b1;
    end else begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  assign w_parity_final = w_acc_next ^ w_odd_eff;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_ACCUM;
      r_first      <= 1'b1;
      r_acc        <= 1'b0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_odd        <= 1'b0;
      r_check      <= 1'b0;
      r_out_parity <= 1'b0;
      r_out_error  <= 1'b0;
      r_out_count  <= '0;
      r_out_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_beat) begin
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
            r_odd   <= w_odd_eff;
            r_check <= w_check_eff;
            r_first <= 1'b0;
            if (in_last) begin
              r_out_parity <= w_parity_final;
              r_out_error  <= w_check_eff && (w_parity_final != in_parity);
              r_out_count  <= w_cnt_next;
              r_out_ovf    <= w_ovf_next;
              r_state      <= ST_DONE;
            end
          end
        end
        default: begin
          if (out_ready) begin
            r_state <= ST_ACCUM;
            r_first <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready     = (r_state == ST_ACCUM);
  assign out_valid    = (r_state == ST_DONE);
  assign out_parity   = r_out_parity;
  assign out_error    = r_out_error;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_ovf;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_frame_parity_unit.sv
// Directed bench for frame_parity_unit (WIDTH=8, MAX_WORDS=4): hand-computed
// results checked with immediate assertions on the falling edge.
module tb_frame_parity_unit;

  localparam int WIDTH     = 8;
  localparam int MAX_WORDS = 4;
  localparam int CW        = $clog2(MAX_WORDS + 1);

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             odd_mode;
  logic             check_mode;
  logic             in_parity;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic             out_error;
  logic [CW-1:0]    out_count;
  logic             out_overflow;
  logic [0:0]       dbg_state;

  int n_tests;
  int n_fail;

  frame_parity_unit #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .odd_mode    (odd_mode),
    .check_mode  (check_mode),
    .in_parity   (in_parity),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_parity  (out_parity),
    .out_error   (out_error),
    .out_count   (out_count),
    .out_overflow(out_overflow),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // drive one beat; returns 1 time unit after the accepting edge
  task automatic beat(input logic [7:0] d, input logic l, input logic o,
                      input logic c, input logic p);
    in_valid   = 1'b1;
    in_data    = d;
    in_last    = l;
    odd_mode   = o;
    check_mode = c;
    in_parity  = p;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
  endtask

  // result must be present at the next falling edge (one-cycle latency)
  task automatic expect_result(input string tag, input logic par, input logic err,
                               input logic [CW-1:0] cnt, input logic ovf);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".parity"}, 32'(out_parity), 32'(par));
    chk({tag, ".error"}, 32'(out_error), 32'(err));
    chk({tag, ".count"}, 32'(out_count), 32'(cnt));
    chk({tag, ".ovf"}, 32'(out_overflow), 32'(ovf));
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    odd_mode = 1'b0; check_mode = 1'b0; in_parity = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.parity", 32'(out_parity), 32'd0);
    chk("rst.error", 32'(out_error), 32'd0);
    chk("rst.count", 32'(out_count), 32'd0);
    chk("rst.ovf", 32'(out_overflow), 32'd0);
    @(posedge clk); #1;

    // single-beat zero frame, even generate
    beat(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_result("single", 1'b0, 1'b0, 3'd1, 1'b0);
    @(negedge clk);
    chk("single.hold_ready", 32'(in_ready), 32'd0);
    pop();
    @(negedge clk);
    chk("single.after_pop_ready", 32'(in_ready), 32'd1);
    chk("single.after_pop_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // 01,03,FF: 11 ones; in_parity ignored in generate mode
    beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_result("three_even", 1'b1, 1'b0, 3'd3, 1'b0);
    pop();

    // odd mode on first beat only; later toggles ignored
    beat(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_result("three_odd", 1'b0, 1'b0, 3'd3, 1'b0);
    pop();

    // check mode: AA,F0 -> 8 ones, even parity bit 0
    beat(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_result("check_ok", 1'b0, 1'b0, 3'd2, 1'b0);
    pop();
    beat(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_result("check_bad", 1'b0, 1'b1, 3'd2, 1'b0);
    pop();

    // six beats with MAX_WORDS=4: count saturates, all six ones still counted
    for (int i = 0; i < 6; i++) beat(8'h01, (i == 5), 1'b0, 1'b0, 1'b0);
    expect_result("overflow", 1'b0, 1'b0, 3'd4, 1'b1);
    pop();
    beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_result("after_ovf", 1'b1, 1'b0, 3'd1, 1'b0);
    pop();

    // backpressure: offered word must not be consumed while DONE
    beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1; odd_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.valid", 32'(out_valid), 32'd1);
      chk("bp.ready", 32'(in_ready), 32'd0);
      chk("bp.parity", 32'(out_parity), 32'd1);
      chk("bp.count", 32'(out_count), 32'd1);
    end
    in_valid = 1'b0; in_last = 1'b0; odd_mode = 1'b0;
    pop();
    @(negedge clk);
    chk("bp.no_consume", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    beat(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_result("bp.next", 1'b0, 1'b0, 3'd1, 1'b0);
    pop();

    // reset mid-frame aborts without a result
    beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort.valid", 32'(out_valid), 32'd0);
    chk("abort.ready", 32'(in_ready), 32'd1);
    chk("abort.count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    beat(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_result("abort.next", 1'b1, 1'b0, 3'd1, 1'b0);
    pop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
